// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central hazard/sequencing controller for the 5-stage pipeline.
//   It combines load-use hazards, ID-stage redirects, instruction-memory
//   wait and the multiply/divide busy window into the PC / IF/ID / ID/EX
//   control strobes. It also keeps saturating stall and flush counters.
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   Rs_id, Rt_id          : source register fields of the instruction in ID
//   UsesRs_id, UsesRt_id  : ID instruction actually reads rs / rt
//   UsesHiLo_id, IsMdu_id : ID instruction reads HI/LO, or is mult/div
//   MemRead_ex, Rt_ex     : EX holds a load that writes Rt_ex
//   MduStart_ex           : mult/div issuing in EX (one-cycle pulse)
//   BranchTaken_id, Jump_id : redirect resolved in ID
//   ImemReady             : fetch data is valid this cycle
//   PCWrite, IFIDWrite    : load enables
//   IFFlush, IDEXFlush    : IF/ID clear, ID/EX bubble insert
//   MduBusy               : MDU window active (excludes the start cycle)
//   StallCycles, FlushEvents : saturating performance counters
module pipeline_hazard_ctrl #(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  Rs_id,
  input  logic [4:0]  Rt_id,
  input  logic        UsesRs_id,
  input  logic        UsesRt_id,
  input  logic        UsesHiLo_id,
  input  logic        IsMdu_id,
  input  logic        MemRead_ex,
  input  logic [4:0]  Rt_ex,
  input  logic        MduStart_ex,
  input  logic        BranchTaken_id,
  input  logic        Jump_id,
  input  logic        ImemReady,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFFlush,
  output logic        IDEXFlush,
  output logic        MduBusy,
  output logic [15:0] StallCycles,
  output logic [15:0] FlushEvents
);

  typedef enum logic {RUN, MDU_BUSY} state_t;

  // Countdown reload value: counting LAT-1 down to 0 gives LAT busy cycles.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LAT - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] mdu_cnt, mdu_cnt_n;

  logic loaduse, mdu_active, id_stall, redirect;

  // Hazard terms. r0 is hardwired zero, so a load into it never hazards.
  always_comb begin
    loaduse    = MemRead_ex && (Rt_ex != 5'd0) &&
                 ((UsesRs_id && (Rs_id == Rt_ex)) ||
                  (UsesRt_id && (Rt_id == Rt_ex)));
    mdu_active = MduStart_ex || (state == MDU_BUSY);
    id_stall   = loaduse || (mdu_active && (UsesHiLo_id || IsMdu_id));
    redirect   = BranchTaken_id || Jump_id;
  end

  // MDU FSM: state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= RUN;
      mdu_cnt <= '0;
    end else begin
      state   <= state_n;
      mdu_cnt <= mdu_cnt_n;
    end
  end

  // MDU FSM: next state. A new start while busy restarts the window.
  always_comb begin
    state_n   = state;
    mdu_cnt_n = mdu_cnt;
    case (state)
      RUN: begin
        if (MduStart_ex) begin
          state_n   = MDU_BUSY;
          mdu_cnt_n = CNT_INIT;
        end
      end
      MDU_BUSY: begin
        if (MduStart_ex)          mdu_cnt_n = CNT_INIT;
        else if (mdu_cnt == '0)   state_n   = RUN;
        else                      mdu_cnt_n = mdu_cnt - 1'b1;
      end
      default: begin
        state_n   = RUN;
        mdu_cnt_n = '0;
      end
    endcase
  end

  // Pipeline control. A stall beats a redirect because the branch operands
  // are not valid yet; a redirect beats imem wait because the fetch in
  // flight is on the wrong path anyway.
  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFFlush   = 1'b0;
    IDEXFlush = 1'b0;
    MduBusy   = (state == MDU_BUSY) && !reset;
    if (reset) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IFFlush   = 1'b1;
      IDEXFlush = 1'b1;
    end else if (id_stall) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXFlush = 1'b1;
    end else if (redirect) begin
      IFFlush   = 1'b1;
    end else if (!ImemReady) begin
      PCWrite   = 1'b0;
      IFFlush   = 1'b1;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clock) begin
    if (reset) begin
      StallCycles <= '0;
      FlushEvents <= '0;
    end else begin
      if (id_stall && (StallCycles != 16'hFFFF))
        StallCycles <= StallCycles + 16'd1;
      if (redirect && !id_stall && (FlushEvents != 16'hFFFF))
        FlushEvents <= FlushEvents + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MDU_LAT=4). Inputs change #1
// after the rising edge; outputs are checked mid-cycle.
module tb_pipeline_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  Rs_id, Rt_id, Rt_ex;
  logic        UsesRs_id, UsesRt_id, UsesHiLo_id, IsMdu_id;
  logic        MemRead_ex, MduStart_ex, BranchTaken_id, Jump_id, ImemReady;
  logic        PCWrite, IFIDWrite, IFFlush, IDEXFlush, MduBusy;
  logic [15:0] StallCycles, FlushEvents;

  int vecs = 0;
  int errs = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  pipeline_hazard_ctrl #(.MDU_LAT(4), .CNT_W(6)) dut (
    .clock(clock), .reset(reset),
    .Rs_id(Rs_id), .Rt_id(Rt_id), .UsesRs_id(UsesRs_id), .UsesRt_id(UsesRt_id),
    .UsesHiLo_id(UsesHiLo_id), .IsMdu_id(IsMdu_id),
    .MemRead_ex(MemRead_ex), .Rt_ex(Rt_ex), .MduStart_ex(MduStart_ex),
    .BranchTaken_id(BranchTaken_id), .Jump_id(Jump_id), .ImemReady(ImemReady),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFFlush(IFFlush),
    .IDEXFlush(IDEXFlush), .MduBusy(MduBusy),
    .StallCycles(StallCycles), .FlushEvents(FlushEvents)
  );

  always #5 clock = ~clock;

  task automatic idle();
    Rs_id = 5'd0; Rt_id = 5'd0; Rt_ex = 5'd0;
    UsesRs_id = 1'b0; UsesRt_id = 1'b0; UsesHiLo_id = 1'b0; IsMdu_id = 1'b0;
    MemRead_ex = 1'b0; MduStart_ex = 1'b0;
    BranchTaken_id = 1'b0; Jump_id = 1'b0; ImemReady = 1'b1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    #1;
    vecs++;
    if ({PCWrite, IFIDWrite, IFFlush, IDEXFlush, MduBusy} !== 5'b00110) begin
      errs++; $display("FAIL reset_ctl got %b want 00110",
                       {PCWrite, IFIDWrite, IFFlush, IDEXFlush, MduBusy});
    end
    tick(); tick();
    reset = 1'b0;
    #1;
    vecs++;
    if ({StallCycles, FlushEvents} !== 32'd0) begin
      errs++; $display("FAIL reset_cnt got %h/%h want 0/0", StallCycles, FlushEvents);
    end
    vecs++;
    if ({PCWrite, IFIDWrite, IFFlush, IDEXFlush, MduBusy} !== 5'b11000) begin
      errs++; $display("FAIL run_ctl got %b want 11000",
                       {PCWrite, IFIDWrite, IFFlush, IDEXFlush, MduBusy});
    end
  endtask

  task automatic test_loaduse();
    // rs match
    idle(); MemRead_ex = 1'b1; Rt_ex = 5'd8; Rs_id = 5'd8; UsesRs_id = 1'b1;
    #1; vecs++;
    if ({PCWrite, IFIDWrite, IFFlush, IDEXFlush} !== 4'b0001) begin
      errs++; $display("FAIL loaduse_rs got %b want 0001", {PCWrite, IFIDWrite, IFFlush, IDEXFlush});
    end
    tick(); exp_stall++; idle(); #1;
    vecs++;
    if ({PCWrite, IFIDWrite, IFFlush, IDEXFlush} !== 4'b1100) begin
      errs++; $display("FAIL loaduse_after got %b want 1100", {PCWrite, IFIDWrite, IFFlush, IDEXFlush});
    end
    vecs++;
    if (StallCycles !== 16'(exp_stall)) begin
      errs++; $display("FAIL loaduse_cnt got %0d want %0d", StallCycles, exp_stall);
    end
    // load into r0 never hazards
    MemRead_ex = 1'b1; Rt_ex = 5'd0; Rs_id = 5'd0; UsesRs_id = 1'b1;
    #1; vecs++;
    if ({PCWrite, IFIDWrite, IFFlush, IDEXFlush} !== 4'b1100) begin
      errs++; $display("FAIL loaduse_r0 got %b want 1100", {PCWrite, IFIDWrite, IFFlush, IDEXFlush});
    end
    tick();
    // rt match
    idle(); MemRead_ex = 1'b1; Rt_ex = 5'd5; Rt_id = 5'd5; UsesRt_id = 1'b1;
    #1; vecs++;
    if ({PCWrite, IFIDWrite, IFFlush, IDEXFlush} !== 4'b0001) begin
      errs++; $display("FAIL loaduse_rt got %b want 0001", {PCWrite, IFIDWrite, IFFlush, IDEXFlush});
    end
    tick(); exp_stall++;
    // field matches but the register is not read
    UsesRt_id = 1'b0; Rs_id = 5'd5;
    #1; vecs++;
    if ({PCWrite, IFIDWrite, IFFlush, IDEXFlush} !== 4'b1100) begin
      errs++; $display("FAIL loaduse_unused got %b want 1100", {PCWrite, IFIDWrite, IFFlush, IDEXFlush});
    end
    tick(); idle(); #1;
    vecs++;
    if (StallCycles !== 16'(exp_stall)) begin
      errs++; $display("FAIL loaduse_cnt2 got %0d want %0d", StallCycles, exp_stall);
    end
  endtask

  task automatic test_branch();
    idle(); BranchTaken_id = 1'b1;
    #1; vecs++;
    if ({PCWrite, IFIDWrite, IFFlush, IDEXFlush} !== 4'b1110) begin
      errs++; $display("FAIL branch got %b want 1110", {PCWrite, IFIDWrite, IFFlush, IDEXFlush});
    end
    tick(); exp_flush++;
    // branch under load-use: stall wins, no flush counted
    MemRead_ex = 1'b1; Rt_ex = 5'd9; Rs_id = 5'd9; UsesRs_id = 1'b1;
    #1; vecs++;
    if ({PCWrite, IFIDWrite, IFFlush, IDEXFlush} !== 4'b0001) begin
      errs++; $display("FAIL branch_stall got %b want 0001", {PCWrite, IFIDWrite, IFFlush, IDEXFlush});
    end
    tick(); exp_stall++;
    // jump with imem wait: redirect still wins
    idle(); Jump_id = 1'b1; ImemReady = 1'b0;
    #1; vecs++;
    if ({PCWrite, IFIDWrite, IFFlush, IDEXFlush} !== 4'b1110) begin
      errs++; $display("FAIL jump_imem got %b want 1110", {PCWrite, IFIDWrite, IFFlush, IDEXFlush});
    end
    tick(); exp_flush++; idle(); #1;
    vecs++;
    if (FlushEvents !== 16'(exp_flush) || StallCycles !== 16'(exp_stall)) begin
      errs++; $display("FAIL branch_cnt got %0d/%0d want %0d/%0d",
                       FlushEvents, StallCycles, exp_flush, exp_stall);
    end
  endtask

  task automatic test_mdu();
    idle(); MduStart_ex = 1'b1; UsesHiLo_id = 1'b1;
    #1; vecs++;
    if ({PCWrite, IFIDWrite, IDEXFlush, MduBusy} !== 4'b0010) begin
      errs++; $display("FAIL mdu_start got %b want 0010", {PCWrite, IFIDWrite, IDEXFlush, MduBusy});
    end
    tick(); exp_stall++;
    MduStart_ex = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1; vecs++;
      if ({PCWrite, IFIDWrite, IDEXFlush, MduBusy} !== 4'b0011) begin
        errs++; $display("FAIL mdu_busy%0d got %b want 0011", k, {PCWrite, IFIDWrite, IDEXFlush, MduBusy});
      end
      tick(); exp_stall++;
    end
    #1; vecs++;
    if ({PCWrite, IFIDWrite, IDEXFlush, MduBusy} !== 4'b1100) begin
      errs++; $display("FAIL mdu_done got %b want 1100", {PCWrite, IFIDWrite, IDEXFlush, MduBusy});
    end
    tick(); idle();
    // IsMdu_id during the start cycle also stalls
    MduStart_ex = 1'b1; IsMdu_id = 1'b1;
    #1; vecs++;
    if ({PCWrite, IDEXFlush} !== 2'b01) begin
      errs++; $display("FAIL mdu_ismdu got %b want 01", {PCWrite, IDEXFlush});
    end
    tick(); exp_stall++;
    idle();
    repeat (5) tick();
    #1; vecs++;
    if (StallCycles !== 16'(exp_stall) || MduBusy !== 1'b0) begin
      errs++; $display("FAIL mdu_cnt got %0d busy=%b want %0d busy=0", StallCycles, MduBusy, exp_stall);
    end
  endtask

  task automatic test_imem();
    for (int c = 1; c <= 3; c++) begin
      idle(); ImemReady = 1'b0; Jump_id = (c == 2);
      #1; vecs++;
      if (c == 2) begin
        if ({PCWrite, IFIDWrite, IFFlush, IDEXFlush} !== 4'b1110) begin
          errs++; $display("FAIL imem_jump got %b want 1110", {PCWrite, IFIDWrite, IFFlush, IDEXFlush});
        end
        exp_flush++;
      end else begin
        if ({PCWrite, IFIDWrite, IFFlush, IDEXFlush} !== 4'b0110) begin
          errs++; $display("FAIL imem_wait%0d got %b want 0110", c, {PCWrite, IFIDWrite, IFFlush, IDEXFlush});
        end
      end
      tick();
    end
    idle(); #1; vecs++;
    if (FlushEvents !== 16'(exp_flush)) begin
      errs++; $display("FAIL imem_cnt got %0d want %0d", FlushEvents, exp_flush);
    end
  endtask

  task automatic test_saturate_reset();
    idle(); MemRead_ex = 1'b1; Rt_ex = 5'd3; Rs_id = 5'd3; UsesRs_id = 1'b1;
    repeat (65540) tick();
    idle(); #1; vecs++;
    if (StallCycles !== 16'hFFFF) begin
      errs++; $display("FAIL stall_sat got %h want ffff", StallCycles);
    end
    // open an MDU window and reset with mdu_cnt == 2
    MduStart_ex = 1'b1;
    tick();
    MduStart_ex = 1'b0;
    tick();
    reset = 1'b1; MemRead_ex = 1'b1; Rt_ex = 5'd3; Rs_id = 5'd3; UsesRs_id = 1'b1;
    BranchTaken_id = 1'b1;
    #1; vecs++;
    if ({PCWrite, IFIDWrite, IFFlush, IDEXFlush, MduBusy} !== 5'b00110) begin
      errs++; $display("FAIL rst_mid_ctl got %b want 00110",
                       {PCWrite, IFIDWrite, IFFlush, IDEXFlush, MduBusy});
    end
    tick();
    reset = 1'b0; idle(); UsesHiLo_id = 1'b1;
    #1; vecs++;
    if ({StallCycles, FlushEvents} !== 32'd0) begin
      errs++; $display("FAIL rst_mid_cnt got %h/%h want 0/0", StallCycles, FlushEvents);
    end
    vecs++;
    if ({PCWrite, IFIDWrite, IFFlush, IDEXFlush, MduBusy} !== 5'b11000) begin
      errs++; $display("FAIL rst_mid_run got %b want 11000",
                       {PCWrite, IFIDWrite, IFFlush, IDEXFlush, MduBusy});
    end
    tick();
    #1; vecs++;
    if (MduBusy !== 1'b0 || StallCycles !== 16'd0) begin
      errs++; $display("FAIL rst_mid_abort got busy=%b stall=%0d want 0/0", MduBusy, StallCycles);
    end
  endtask

  initial begin
    test_reset();
    test_loaduse();
    test_branch();
    test_mdu();
    test_imem();
    test_saturate_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard/sequencing controller for the 5-stage pipeline.
- Generates PC write-enable, IF/ID write-enable, the IF/ID flush (IFFlush) and ID/EX bubble controls from:
  - load-use hazards,
  - ID-stage branch/jump redirects,
  - instruction-memory wait,
  - a multi-cycle multiply/divide unit (MDU) busy window.
- Also keeps saturating stall and flush performance counters.

Parameters:
- MDU_LAT, 32, MDU busy cycles after the start cycle; 1 <= MDU_LAT <= 2^CNT_W.
- CNT_W, 6, width of the MDU countdown counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Rs_id  in  5  rs field of the instruction in ID.
- Rt_id  in  5  rt field of the instruction in ID.
- UsesRs_id  in  1  ID instruction reads rs.
- UsesRt_id  in  1  ID instruction reads rt.
- UsesHiLo_id  in  1  ID instruction reads HI/LO (mfhi/mflo).
- IsMdu_id  in  1  ID instruction is mult/div.
- MemRead_ex  in  1  EX instruction is a load.
- Rt_ex  in  5  load destination register in EX.
- MduStart_ex  in  1  one-cycle pulse: mult/div issuing in EX.
- BranchTaken_id  in  1  branch resolved taken in ID.
- Jump_id  in  1  jump/jr in ID.
- ImemReady  in  1  instruction memory returns a valid fetch this cycle.
- PCWrite  out  1  PC register load enable.
- IFIDWrite  out  1  IF/ID register load enable.
- IFFlush  out  1  IF/ID clears to 0 at next edge.
- IDEXFlush  out  1  ID/EX loads a bubble at next edge.
- MduBusy  out  1  state == MDU_BUSY.
- StallCycles  out  16  saturating count of ID-stall cycles.
- FlushEvents  out  16  saturating count of redirect flushes.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; ports are named clock and reset.
- State register: RUN, MDU_BUSY. The countdown counter mdu_cnt is CNT_W bits wide.

Reset (reset=1 at an edge):
- state <= RUN, mdu_cnt <= 0, StallCycles <= 0, FlushEvents <= 0.
- While reset=1 the outputs are forced: PCWrite=0, IFIDWrite=0, IFFlush=1, IDEXFlush=1, MduBusy=0.
- A reset mid-MDU-window aborts the window. The first cycle after reset is RUN.

Combinational terms (same cycle, no latency):
- loaduse = MemRead_ex & (Rt_ex != 0) & ((UsesRs_id & Rs_id == Rt_ex) | (UsesRt_id & Rt_id == Rt_ex)).
- mdu_active = MduStart_ex | (state == MDU_BUSY).
- id_stall = loaduse | (mdu_active & (UsesHiLo_id | IsMdu_id)).
- redirect = BranchTaken_id | Jump_id.

Output priority (first match wins). Values listed as PCWrite/IFIDWrite/IFFlush/IDEXFlush:
1. id_stall: 0/0/0/1. A redirect is ignored, because its operands are not valid yet.
2. redirect: 1/1/1/0. The redirect still wins when ImemReady=0.
3. !ImemReady: 0/1/1/0. A bubble enters ID and the PC holds.
4. Otherwise: 1/1/0/0.

MDU FSM (evaluated at each clock edge):
- RUN with MduStart_ex → MDU_BUSY, mdu_cnt <= MDU_LAT-1.
- MDU_BUSY with MduStart_ex → restart: mdu_cnt <= MDU_LAT-1.
- MDU_BUSY with mdu_cnt == 0 → RUN.
- MDU_BUSY otherwise → mdu_cnt <= mdu_cnt - 1.
- Net effect: MduBusy is high for exactly MDU_LAT cycles following the start cycle.

Counters:
- StallCycles += 1 in each cycle where id_stall=1.
- FlushEvents += 1 in each cycle where redirect=1 and id_stall=0.
- Both saturate at 0xFFFF and never wrap.
- Neither counter increments while reset=1.

Test Plan:
- Load-use: MemRead_ex=1, Rt_ex=8, Rs_id=8, UsesRs_id=1 for one cycle → PCWrite=0, IFIDWrite=0, IDEXFlush=1 for that cycle only; StallCycles 0→1. Repeat with Rt_ex=0 → no stall.
- Branch: BranchTaken_id=1, no hazard → IFFlush=1, PCWrite=1, FlushEvents+1. Same cycle with loaduse=1 → IFFlush=0, IDEXFlush=1, FlushEvents unchanged.
- MDU window, MDU_LAT=4: MduStart_ex at cycle t → MduBusy=1 for cycles t+1..t+4, 0 at t+5. UsesHiLo_id=1 during cycles t..t+4 → stall in each, StallCycles +5; UsesHiLo_id=1 at t+5 → no stall.
- Imem wait: ImemReady=0 for 3 cycles, no hazard → PCWrite=0, IFFlush=1, IFIDWrite=1 each cycle. Jump_id=1 in cycle 2 → PCWrite=1 in that cycle.
- Saturation/reset: preload via 65540 stall cycles → StallCycles holds 0xFFFF. Assert reset during MDU_BUSY (mdu_cnt=2) → next cycle state RUN, MduBusy=0, both counters 0, and the reset-cycle outputs are 0/0/1/1.
